// File: rtl/lenet_fc_pkg.sv
// +--------------------------------------------------------------------------+
// | lenet_fc_pkg : shared LeNet FC-stage defaults and argmax state encodings  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package lenet_fc_pkg;

  localparam int NUM_CLASS_DEF = 10;
  localparam int DATA_W_DEF    = 16;
  localparam int ADDR_W_DEF    = 4;

  localparam logic [3:0] c_st_idle  = 4'b0001;
  localparam logic [3:0] c_st_run   = 4'b0010;
  localparam logic [3:0] c_st_drain = 4'b0100;
  localparam logic [3:0] c_st_done  = 4'b1000;

  typedef enum logic [3:0] {
    IDLE  = c_st_idle,
    RUN   = c_st_run,
    DRAIN = c_st_drain,
    DONE  = c_st_done
  } argmax_state_t;

endpackage

`default_nettype wire

// File: rtl/f8_rd_pipe.sv
// +--------------------------------------------------------------------------+
// | f8_rd_pipe : DEPTH-stage {valid, index} delay line matching RAM latency   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module f8_rd_pipe #(
  parameter int DEPTH = 1,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_vld,
  input  logic [IDX_W-1:0] i_idx,
  output logic             o_vld,
  output logic [IDX_W-1:0] o_idx
);

  logic             r_vld [DEPTH];
  logic [IDX_W-1:0] r_idx [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_vld[i] <= 1'b0;
        r_idx[i] <= '0;
      end
    end else begin
      r_vld[0] <= i_vld;
      r_idx[0] <= i_idx;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_idx[i] <= r_idx[i-1];
      end
    end
  end

  assign o_vld = r_vld[DEPTH-1];
  assign o_idx = r_idx[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/f8_argmax.sv
// +--------------------------------------------------------------------------+
// | f8_argmax : scans the FC3 score RAM and reports the winning class.        |
// | Optional runner-up margin output: F8_ARGMAX_MARGIN_EN. Revision 1.0       |
// +--------------------------------------------------------------------------+
`default_nettype none

module f8_argmax
  import lenet_fc_pkg::*;
#(
  parameter int NUM_CLASS = NUM_CLASS_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              argmax_start,
  output logic              f8_rd_en,
  output logic [ADDR_W-1:0] f8_raddr,
  input  logic [DATA_W-1:0] f8_rdata,
  output logic              argmax_busy,
  output logic              argmax_done,
  output logic [ADDR_W-1:0] class_idx,
  output logic [DATA_W-1:0] class_score
`ifdef F8_ARGMAX_MARGIN_EN
  ,
  output logic [DATA_W:0]   class_margin
`endif
);

  localparam logic [ADDR_W-1:0] c_last_addr  = ADDR_W'(NUM_CLASS - 1);
  localparam logic [1:0]        c_last_drain = 2'(RD_LAT - 1);

  argmax_state_t     r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]        r_drain, w_drain_nxt;
  logic              r_rd_en, r_busy, r_done;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_drain_nxt = r_drain;
    unique case (r_state)
      IDLE:  if (argmax_start) w_state_nxt = RUN;
      RUN: begin
        if (r_cnt == c_last_addr) begin
          w_state_nxt = DRAIN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (r_drain == c_last_drain) begin
          w_state_nxt = DONE;
          w_drain_nxt = '0;
        end else begin
          w_drain_nxt = r_drain + 2'd1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output flags are decoded from the next state so they appear as flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_drain <= '0;
      r_rd_en <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_drain <= w_drain_nxt;
      r_rd_en <= (w_state_nxt == RUN);
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= (w_state_nxt == DONE);
    end
  end

  logic              w_vld;
  logic [ADDR_W-1:0] w_idx;

  f8_rd_pipe #(
    .DEPTH (RD_LAT),
    .IDX_W (ADDR_W)
  ) u_rd_pipe (
    .clk   (clk),
    .rst   (rst),
    .i_vld (r_rd_en),
    .i_idx (r_cnt),
    .o_vld (w_vld),
    .o_idx (w_idx)
  );

  logic signed [DATA_W-1:0] w_data;
  logic signed [DATA_W-1:0] r_best, w_best_nxt;
  logic        [ADDR_W-1:0] r_best_idx, w_best_idx_nxt;
  logic                     w_new_best;
  logic        [ADDR_W-1:0] r_class_idx;
  logic        [DATA_W-1:0] r_class_score;

  assign w_data = f8_rdata;

  // Strict compare: a tie never displaces the earlier (lower) index.
  always_comb begin
    w_best_nxt     = r_best;
    w_best_idx_nxt = r_best_idx;
    w_new_best     = 1'b0;
    if (w_vld && ((w_idx == '0) || (w_data > r_best))) begin
      w_new_best     = 1'b1;
      w_best_nxt     = w_data;
      w_best_idx_nxt = w_idx;
    end
  end

  // Results are captured on entry to DONE so they are visible in that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_best        <= '0;
      r_best_idx    <= '0;
      r_class_idx   <= '0;
      r_class_score <= '0;
    end else begin
      r_best     <= w_best_nxt;
      r_best_idx <= w_best_idx_nxt;
      if (w_state_nxt == DONE) begin
        r_class_idx   <= w_best_idx_nxt;
        r_class_score <= w_best_nxt;
      end
    end
  end

`ifdef F8_ARGMAX_MARGIN_EN
  logic signed [DATA_W-1:0] r_run, w_run_nxt;
  logic                     r_run_vld, w_run_vld_nxt;
  logic        [DATA_W:0]   w_margin;
  logic        [DATA_W:0]   r_class_margin;

  always_comb begin
    w_run_nxt     = r_run;
    w_run_vld_nxt = r_run_vld;
    if (w_vld) begin
      if (w_idx == '0) begin
        w_run_vld_nxt = 1'b0;
      end else if (w_new_best) begin
        w_run_nxt     = r_best;
        w_run_vld_nxt = 1'b1;
      end else if (!r_run_vld || (w_data > r_run)) begin
        w_run_nxt     = w_data;
        w_run_vld_nxt = 1'b1;
      end
    end
    w_margin = '0;
    if (w_run_vld_nxt) begin
      w_margin = {w_best_nxt[DATA_W-1], w_best_nxt} - {w_run_nxt[DATA_W-1], w_run_nxt};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run          <= '0;
      r_run_vld      <= 1'b0;
      r_class_margin <= '0;
    end else begin
      r_run     <= w_run_nxt;
      r_run_vld <= w_run_vld_nxt;
      if (w_state_nxt == DONE) r_class_margin <= w_margin;
    end
  end

  assign class_margin = r_class_margin;
`endif

  assign f8_rd_en    = r_rd_en;
  assign f8_raddr    = r_cnt;
  assign argmax_busy = r_busy;
  assign argmax_done = r_done;
  assign class_idx   = r_class_idx;
  assign class_score = r_class_score;

endmodule

`default_nettype wire
